// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbitrating master and a single slave.
// The master modport drives the request phase; the slave answers with data and status.
interface apb_master_arbiter_if #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 8
);
   logic                 PSEL;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [ADDRWIDTH-1:0] PADDR;
   logic [DATAWIDTH-1:0] PWDATA;
   logic [DATAWIDTH-1:0] PRDATA;
   logic                 PREADY;
   logic                 PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one slave between NREQ requesters,
// with a wait-state timeout that aborts a transfer the slave never completes.
module apb_master_arbiter #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 8,
   parameter int NREQ      = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_write,
   input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
   input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]           req_gnt,
   output logic [NREQ-1:0]           req_done,
   output logic [DATAWIDTH-1:0]      req_rdata,
   output logic                      req_err,
   apb_master_arbiter_if.master      apb
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [NREQ-1:0]      done_q, done_d;
   logic [DATAWIDTH-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 psel_q, psel_d;
   logic                 pen_q, pen_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
   logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;

   logic [NREQ-1:0]      elig;
   logic [PW-1:0]        win;
   logic                 found;

   // Requester finishing this cycle sits out one arbitration round.
   always_comb begin
      elig  = req_valid & ~done_q;
      win   = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && elig[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            win   = PW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      psel_d   = psel_q;
      pen_d    = pen_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               ptr_d    = win;
               gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
               pwrite_d = req_write[win];
               paddr_d  = req_addr[win*ADDRWIDTH +: ADDRWIDTH];
               pwdata_d = req_wdata[win*DATAWIDTH +: DATAWIDTH];
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            pen_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb.PREADY) begin
               done_d  = gnt_q;
               err_d   = apb.PSLVERR;
               if (!pwrite_q) rdata_d = apb.PRDATA;
               psel_d  = 1'b0;
               pen_d   = 1'b0;
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else if (TIMEOUT != 0 &&
                         cnt_q == CW'(TIMEOUT - 1)) begin
               done_d  = gnt_q;
               err_d   = 1'b1;
               rdata_d = '0;
               psel_d  = 1'b0;
               pen_d   = 1'b0;
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q  <= ST_IDLE;
         ptr_q    <= PW'(NREQ - 1);
         cnt_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
      end
   end

   assign req_gnt     = gnt_q;
   assign req_done    = done_q;
   assign req_rdata   = rdata_q;
   assign req_err     = err_q;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = pen_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level model checked every cycle
// plus directed latency, wait-state, contention, error, timeout and reset cases.
module tb_apb_master_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int NR = 2;
   localparam int TO = 16;

   logic           PCLK = 1'b0;
   logic           PRESET = 1'b0;
   logic [NR-1:0]  req_valid = '0;
   logic [NR-1:0]  req_write = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]  req_gnt;
   logic [NR-1:0]  req_done;
   logic [DW-1:0]  req_rdata;
   logic           req_err;

   apb_master_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) apb ();

   apb_master_arbiter #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .NREQ(NR), .TIMEOUT(TO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_gnt(req_gnt), .req_done(req_done),
      .req_rdata(req_rdata), .req_err(req_err),
      .apb(apb)
   );

   always #5 PCLK = ~PCLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Slave: answers after s_ws wait states, or never when s_hang is set.
   int         s_ws = 0;
   logic       s_hang = 1'b0;
   logic       s_err = 1'b0;
   logic [7:0] s_rdata = 8'h00;
   int         s_acc = 0;

   initial begin
      apb.PREADY = 1'b0;
      apb.PRDATA = '0;
      apb.PSLVERR = 1'b0;
   end

   always @(negedge PCLK) begin
      if (apb.PSEL && apb.PENABLE) begin
         apb.PREADY  = !s_hang && (s_acc == s_ws);
         apb.PRDATA  = apb.PREADY ? s_rdata : 8'h00;
         apb.PSLVERR = apb.PREADY && s_err;
         s_acc++;
      end else begin
         apb.PREADY  = 1'b0;
         apb.PRDATA  = 8'h00;
         apb.PSLVERR = 1'b0;
         s_acc = 0;
      end
   end

   // Transaction model: one transfer at a time, age counts cycles since grant.
   logic        m_busy;
   int          m_owner, m_ptr, m_age, m_c;
   logic [NR-1:0] m_done, m_nd, m_elig;
   logic        m_err, m_write;
   logic [7:0]  m_rdata, m_wdata;
   logic [15:0] m_addr;

   always @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         m_busy = 0; m_owner = 0; m_ptr = NR - 1; m_age = 0;
         m_done = '0; m_err = 0; m_rdata = 0;
         m_write = 0; m_addr = 0; m_wdata = 0;
      end else begin
         m_nd = '0;
         if (!m_busy) begin
            m_elig = req_valid & ~m_done;
            for (int k = 1; k <= NR; k++) begin
               m_c = (m_ptr + k) % NR;
               if (!m_busy && m_elig[m_c]) begin
                  m_busy = 1; m_owner = m_c; m_ptr = m_c; m_age = 1;
                  m_write = req_write[m_c];
                  m_addr  = req_addr[m_c*AW +: AW];
                  m_wdata = req_wdata[m_c*DW +: DW];
               end
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (apb.PREADY) begin
            m_nd[m_owner] = 1'b1;
            m_err = apb.PSLVERR;
            if (!m_write) m_rdata = apb.PRDATA;
            m_busy = 0;
         end else if (TO != 0 && m_age - 1 == TO) begin
            m_nd[m_owner] = 1'b1;
            m_err = 1'b1;
            m_rdata = 8'h00;
            m_busy = 0;
         end else begin
            m_age++;
         end
         m_done = m_nd;
      end
   end

   logic cmp_en = 1'b0;

   always @(negedge PCLK) begin
      if (cmp_en) begin
         chk("m_psel", apb.PSEL, m_busy);
         chk("m_penable", apb.PENABLE, m_busy && m_age >= 2);
         chk("m_gnt", req_gnt, m_busy ? (2'b01 << m_owner) : 2'b00);
         chk("m_done", req_done, m_done);
         chk("m_err", req_err, m_err);
         chk("m_rdata", req_rdata, m_rdata);
         chk("m_pwrite", apb.PWRITE, m_write);
         chk("m_paddr", apb.PADDR, m_addr);
         chk("m_pwdata", apb.PWDATA, m_wdata);
      end
   end

   task automatic run1(input int i, output int pen, output logic ok,
                       output logic err, output logic [7:0] rd);
      pen = 0; ok = 0; err = 0; rd = 0;
      @(negedge PCLK);
      req_valid[i] = 1'b1;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge PCLK);
         if (apb.PENABLE) pen++;
         if (req_done[i]) begin
            ok = 1; err = req_err; rd = req_rdata;
            req_valid[i] = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pen, extra, got, ord[4];
      logic ok, err, gap;
      logic [7:0] rd;

      // Reset values
      #12;
      chk("rst_psel", apb.PSEL, 0);
      chk("rst_penable", apb.PENABLE, 0);
      chk("rst_gnt", req_gnt, 0);
      chk("rst_done", req_done, 0);
      chk("rst_rdata", req_rdata, 0);
      @(negedge PCLK);
      PRESET = 1'b1;
      cmp_en = 1'b1;

      // 1: write, zero wait
      req_write[0] = 1'b1; req_addr[15:0] = 16'h0003; req_wdata[7:0] = 8'hA5;
      @(negedge PCLK);
      req_valid[0] = 1'b1;
      @(negedge PCLK);
      chk("t1_psel", apb.PSEL, 1);
      chk("t1_pen0", apb.PENABLE, 0);
      chk("t1_pwrite", apb.PWRITE, 1);
      chk("t1_paddr", apb.PADDR, 16'h0003);
      chk("t1_pwdata", apb.PWDATA, 8'hA5);
      chk("t1_gnt", req_gnt, 2'b01);
      @(negedge PCLK);
      chk("t1_pen1", apb.PENABLE, 1);
      @(negedge PCLK);
      chk("t1_done", req_done, 2'b01);
      chk("t1_err", req_err, 0);
      chk("t1_psel_off", apb.PSEL, 0);
      req_valid[0] = 1'b0;
      @(negedge PCLK);
      chk("t1_done_off", req_done, 0);

      // 2: read, two wait states
      s_ws = 2; s_rdata = 8'h5A;
      req_write[1] = 1'b0; req_addr[31:16] = 16'h000A;
      run1(1, pen, ok, err, rd);
      chk("t2_seen", ok, 1);
      chk("t2_pen_cycles", pen, 3);
      chk("t2_rdata", rd, 8'h5A);
      extra = 0;
      repeat (4) begin
         @(negedge PCLK);
         if (req_done[1]) extra++;
      end
      chk("t2_done_count", 1 + extra, 1);
      s_ws = 0;

      // 3: contention, grant order 0,1,0,1
      req_write = 2'b11; req_addr = {16'h0200, 16'h0100};
      req_wdata = {8'h22, 8'h11};
      @(negedge PCLK);
      req_valid = 2'b11;
      got = 0; gap = 0;
      for (int n = 0; n < 200 && got < 4; n++) begin
         @(negedge PCLK);
         if (gap) begin
            chk("t3_one_idle", apb.PSEL, 1);
            gap = 0;
         end
         if (req_done != 0) begin
            ord[got] = req_done[1] ? 1 : 0;
            got++;
            if (got == 4) req_valid = 2'b00;
            else gap = 1;
         end
      end
      chk("t3_count", got, 4);
      chk("t3_ord0", ord[0], 0);
      chk("t3_ord1", ord[1], 1);
      chk("t3_ord2", ord[2], 0);
      chk("t3_ord3", ord[3], 1);
      @(negedge PCLK);

      // 4: slave error then clean transfer
      s_err = 1'b1;
      req_write[0] = 1'b1; req_addr[15:0] = 16'h0044; req_wdata[7:0] = 8'h3C;
      run1(0, pen, ok, err, rd);
      chk("t4_seen", ok, 1);
      chk("t4_err", err, 1);
      s_err = 1'b0;
      @(negedge PCLK);
      run1(0, pen, ok, err, rd);
      chk("t4_clean_seen", ok, 1);
      chk("t4_clean_err", err, 0);

      // 5: timeout
      @(negedge PCLK);
      s_hang = 1'b1;
      req_write[0] = 1'b0; req_addr[15:0] = 16'h0077;
      run1(0, pen, ok, err, rd);
      chk("t5_seen", ok, 1);
      chk("t5_access_cycles", pen, 16);
      chk("t5_err", err, 1);
      chk("t5_rdata", rd, 8'h00);
      chk("t5_psel", apb.PSEL, 0);

      // 6: reset in ACCESS
      @(negedge PCLK);
      req_valid[1] = 1'b1;
      ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge PCLK);
         if (apb.PENABLE) ok = 1;
      end
      chk("t6_reached_access", ok, 1);
      @(posedge PCLK);
      #2 PRESET = 1'b0;
      #1;
      chk("t6_psel", apb.PSEL, 0);
      chk("t6_penable", apb.PENABLE, 0);
      chk("t6_gnt", req_gnt, 0);
      chk("t6_done", req_done, 0);
      req_valid = 2'b11;
      req_write = 2'b00;
      s_hang = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b1;
      ok = 0;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge PCLK);
         if (req_gnt != 0) begin
            ok = 1;
            chk("t6_first_gnt", req_gnt, 2'b01);
         end
      end
      chk("t6_granted", ok, 1);
      for (int n = 0; n < 60 && req_valid != 0; n++) begin
         @(negedge PCLK);
         if (req_done[0]) req_valid[0] = 1'b0;
         if (req_done[1]) req_valid[1] = 1'b0;
      end
      chk("t6_both_served", req_valid, 2'b00);
      repeat (3) @(negedge PCLK);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
